// File: rtl/seq_mul_32.sv
// Iterative 32x32->64 MULT/MULTU unit for the EX stage. It uses one cla_32 adder
// for operand magnitudes, 32 shift-add iterations and a two-pass result negate.

module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        g_out,
    output logic        p_out
);

    logic [31:0] g_s;
    logic [31:0] p_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Bit sums plus group generate/propagate, so carry-out = g_out | (p_out & c_in)
    always_comb begin : add_blk
        logic c_v;
        logic gg_v;
        logic pp_v;
        c_v   = c_in;
        gg_v  = 1'b0;
        pp_v  = 1'b1;
        sum   = 32'd0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = p_s[i] ^ c_v;
            c_v    = g_s[i] | (p_s[i] & c_v);
            gg_v   = g_s[i] | (p_s[i] & gg_v);
            pp_v   = pp_v & p_s[i];
        end
        g_out = gg_v;
        p_out = pp_v;
    end

endmodule

module seq_mul_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        stall
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        MUL    = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sgn_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplr_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   lo_tmp_r;
    logic               neg_r;
    logic               c_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic [WIDTH-1:0]   cla_a_s;
    logic [WIDTH-1:0]   cla_b_s;
    logic               cla_cin_s;
    logic [WIDTH-1:0]   cla_sum_s;
    logic               cla_g_s;
    logic               cla_p_s;
    logic               idle_or_done_s;
    logic               busy_s;
    logic               accept_s;
    logic               neg_a_s;
    logic               neg_b_s;

    cla_32 u_cla (
        .a     (cla_a_s),
        .b     (cla_b_s),
        .c_in  (cla_cin_s),
        .sum   (cla_sum_s),
        .g_out (cla_g_s),
        .p_out (cla_p_s)
    );

    assign idle_or_done_s = (state_r == IDLE) || (state_r == DONE);
    assign busy_s         = (state_r == ABS_A) || (state_r == ABS_B) || (state_r == MUL) ||
                            (state_r == NEG_LO) || (state_r == NEG_HI);
    assign accept_s       = idle_or_done_s && start && !flush;
    assign neg_a_s        = sgn_r & a_r[WIDTH-1];
    assign neg_b_s        = sgn_r & b_r[WIDTH-1];

    assign stall = (start & idle_or_done_s) | busy_s;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign done  = done_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush aborts any busy state straight to IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: state_next_s = accept_s ? ABS_A : IDLE;
            ABS_A:      state_next_s = flush ? IDLE : ABS_B;
            ABS_B:      state_next_s = flush ? IDLE : MUL;
            MUL: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b1}}) begin
                    state_next_s = NEG_LO;
                end else begin
                    state_next_s = MUL;
                end
            end
            NEG_LO:     state_next_s = flush ? IDLE : NEG_HI;
            NEG_HI:     state_next_s = flush ? IDLE : DONE;
            default:    state_next_s = IDLE;
        endcase
    end

    // Adder operand selection for each phase of the operation
    always_comb begin
        cla_a_s   = {WIDTH{1'b0}};
        cla_b_s   = {WIDTH{1'b0}};
        cla_cin_s = 1'b0;
        case (state_r)
            ABS_A: begin
                cla_a_s   = neg_a_s ? ~a_r : a_r;
                cla_cin_s = neg_a_s;
            end
            ABS_B: begin
                cla_a_s   = neg_b_s ? ~b_r : b_r;
                cla_cin_s = neg_b_s;
            end
            MUL: begin
                cla_a_s = acc_r;
                cla_b_s = mplr_r[0] ? mcand_r : {WIDTH{1'b0}};
            end
            NEG_LO: begin
                cla_a_s   = neg_r ? ~mplr_r : mplr_r;
                cla_cin_s = neg_r;
            end
            NEG_HI: begin
                cla_a_s   = neg_r ? ~acc_r : acc_r;
                cla_cin_s = neg_r & c_r;
            end
            default: begin
                cla_a_s   = {WIDTH{1'b0}};
                cla_b_s   = {WIDTH{1'b0}};
                cla_cin_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iterations and result commit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sgn_r    <= 1'b0;
            mcand_r  <= {WIDTH{1'b0}};
            mplr_r   <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            lo_tmp_r <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            c_r      <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_next_s == DONE);
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= is_signed;
                        acc_r <= {WIDTH{1'b0}};
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ABS_A: mcand_r <= cla_sum_s;
                ABS_B: begin
                    mplr_r <= cla_sum_s;
                    neg_r  <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                end
                MUL: begin
                    // 65-bit {carry, sum, mplr} shifted right by one into {acc, mplr}
                    acc_r  <= {cla_g_s, cla_sum_s[WIDTH-1:1]};
                    mplr_r <= {cla_sum_s[0], mplr_r[WIDTH-1:1]};
                    cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                NEG_LO: begin
                    lo_tmp_r <= cla_sum_s;
                    c_r      <= cla_g_s | cla_p_s;
                end
                NEG_HI: begin
                    if (!flush) begin
                        hi_r <= cla_sum_s;
                        lo_r <= lo_tmp_r;
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
